// File: rtl/softermax_result_serializer.sv
// Output-side unloader for softermax_wrapper: captures a whole result vector in one
// handshake and replays it element by element on a valid/ready stream.
module softermax_result_serializer #(
  parameter int VEC_SIZE = 10,
  parameter int OUT_W    = 32,
  parameter int IDX_W    = $clog2(VEC_SIZE),
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [OUT_W-1:0] vec_data [VEC_SIZE-1:0],
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [IDX_W-1:0] m_idx,
  output logic             m_last,
  output logic [CNT_W-1:0] vec_count
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_SIZE - 1);

  typedef enum logic {S_EMPTY, S_STREAM} act_state_t;

  act_state_t       state, next_state;
  logic             pend_full, next_pend_full;
  logic [IDX_W-1:0] idx_q, next_idx;
  logic [OUT_W-1:0] data_q, next_data;
  logic             last_q, next_last;
  logic [CNT_W-1:0] cnt_q;

  logic [OUT_W-1:0] act_buf  [VEC_SIZE-1:0];
  logic [OUT_W-1:0] pend_buf [VEC_SIZE-1:0];

  logic accept, xfer;
  logic load_in, load_pend, capture_pend, advance, count_inc;

  // State register: control state and registered stream outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= S_EMPTY;
      pend_full <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= next_state;
      pend_full <= next_pend_full;
      idx_q     <= next_idx;
      data_q    <= next_data;
      last_q    <= next_last;
      if (count_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the vector buffers are datapath storage qualified by state, so they are
  // left without reset; stale contents are never emitted after a reset.
  always_ff @(posedge clk) begin
    if (load_in)        act_buf <= vec_data;
    else if (load_pend) act_buf <= pend_buf;
    if (capture_pend)   pend_buf <= vec_data;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    next_state     = state;
    next_pend_full = pend_full;
    next_idx       = idx_q;
    load_in        = 1'b0;
    load_pend      = 1'b0;
    capture_pend   = 1'b0;
    advance        = 1'b0;
    count_inc      = 1'b0;
    accept         = vec_valid & ~pend_full;
    xfer           = (state == S_STREAM) & m_ready;

    case (state)
      S_EMPTY: begin
        if (accept) begin
          load_in    = 1'b1;
          next_state = S_STREAM;
          next_idx   = '0;
        end
      end
      S_STREAM: begin
        if (xfer && idx_q == LAST) begin
          count_inc = 1'b1;
          next_idx  = '0;
          // Pending vector (or a same-cycle arrival) takes over without a bubble.
          if (pend_full) begin
            load_pend      = 1'b1;
            next_pend_full = 1'b0;
          end else if (accept) begin
            load_in = 1'b1;
          end else begin
            next_state = S_EMPTY;
          end
        end else begin
          if (xfer) begin
            advance  = 1'b1;
            next_idx = idx_q + 1'b1;
          end
          if (accept) begin
            capture_pend   = 1'b1;
            next_pend_full = 1'b1;
          end
        end
      end
      default: next_state = S_EMPTY;
    endcase

    next_data = data_q;
    if (load_in)        next_data = vec_data[0];
    else if (load_pend) next_data = pend_buf[0];
    else if (advance)   next_data = act_buf[idx_q + 1'b1];

    next_last = (next_state == S_STREAM) && (next_idx == LAST);
  end

  // Output logic.
  always_comb begin
    m_valid   = (state == S_STREAM);
    vec_ready = ~pend_full;
    m_data    = data_q;
    m_idx     = idx_q;
    m_last    = last_q;
    vec_count = cnt_q;
  end

endmodule

// File: tb/tb_softermax_result_serializer.sv
// Directed bench for softermax_result_serializer; a second instance with a 2-bit
// counter shares the stimulus to exercise vec_count wrap.
module tb_softermax_result_serializer;

  localparam int VS = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_valid;
  logic        m_ready;
  logic [31:0] vec_data [VS-1:0];

  logic        vec_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_idx;
  logic [15:0] vec_count;

  logic        vec_ready_w, m_valid_w, m_last_w;
  logic [31:0] m_data_w;
  logic [3:0]  m_idx_w;
  logic [1:0]  vec_count_w;

  int n_vec = 0;
  int n_err = 0;

  softermax_result_serializer dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_idx(m_idx), .m_last(m_last), .vec_count(vec_count)
  );

  softermax_result_serializer #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready_w),
    .vec_data(vec_data), .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w),
    .m_idx(m_idx_w), .m_last(m_last_w), .vec_count(vec_count_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [31:0] base);
    for (int i = 0; i < VS; i++) vec_data[i] = base + 32'(i);
  endtask

  task automatic expect_elem(input string tag, input logic [31:0] data, input int idx);
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    check({tag, "_data"}, m_data, data);
    check({tag, "_idx"}, {28'd0, m_idx}, 32'(idx));
    check({tag, "_last"}, {31'd0, m_last}, (idx == VS - 1) ? 32'd1 : 32'd0);
    check({tag, "_w_data"}, m_data_w, data);
    check({tag, "_w_idx"}, {28'd0, m_idx_w}, 32'(idx));
    check({tag, "_w_last"}, {31'd0, m_last_w}, (idx == VS - 1) ? 32'd1 : 32'd0);
  endtask

  // Offer one vector while idle, then stream it with m_ready held high.
  task automatic send_and_stream(input string tag, input logic [31:0] base);
    set_vec(base);
    vec_valid = 1'b1;
    m_ready   = 1'b1;
    check({tag, "_pre_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_pre_ready"}, {31'd0, vec_ready}, 32'd1);
    tick();
    vec_valid = 1'b0;
    set_vec(32'hBAD0_0000);
    for (int i = 0; i < VS; i++) begin
      expect_elem(tag, base + 32'(i), i);
      tick();
    end
    check({tag, "_post_valid"}, {31'd0, m_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_e;
    int transfers;
    int k;
    bit acc;
    int produced;
    logic [1:0] wrap_exp [5];

    // 1: reset held two cycles with vec_valid asserted
    rst_n     = 1'b0;
    vec_valid = 1'b1;
    m_ready   = 1'b1;
    set_vec(32'hDEAD_0000);
    tick();
    tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_count", {16'd0, vec_count}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_idx", {28'd0, m_idx}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    rst_n     = 1'b1;
    vec_valid = 1'b0;
    tick();
    check("rel_vec_ready", {31'd0, vec_ready}, 32'd1);
    check("rel_m_valid", {31'd0, m_valid}, 32'd0);

    // 2: single vector, no backpressure
    send_and_stream("single", 32'h100);
    check("single_count", {16'd0, vec_count}, 32'd1);

    // 3: backpressure pattern 1,0,0,1,0,0,...
    set_vec(32'h200);
    vec_valid = 1'b1;
    m_ready   = 1'b0;
    tick();
    vec_valid = 1'b0;
    set_vec(32'hBAD1_0000);
    exp_e     = 0;
    transfers = 0;
    k         = 0;
    while (exp_e < VS && k < 60) begin
      m_ready = (k % 3 == 0);
      check("bp_valid", {31'd0, m_valid}, 32'd1);
      check("bp_data", m_data, 32'h200 + 32'(exp_e));
      check("bp_idx", {28'd0, m_idx}, 32'(exp_e));
      check("bp_last", {31'd0, m_last}, (exp_e == VS - 1) ? 32'd1 : 32'd0);
      tick();
      if (m_ready) begin
        exp_e++;
        transfers++;
      end
      k++;
    end
    m_ready = 1'b0;
    check("bp_transfers", 32'(transfers), 32'd10);
    check("bp_post_valid", {31'd0, m_valid}, 32'd0);
    check("bp_count", {16'd0, vec_count}, 32'd2);

    // 4: back-to-back vectors A,B,C
    do_reset();
    tick();
    set_vec(32'h300);
    vec_valid = 1'b1;
    m_ready   = 1'b1;
    check("b2b_pre_ready", {31'd0, vec_ready}, 32'd1);
    tick();
    produced = 1;
    set_vec(32'h400);
    for (int j = 0; j < 3 * VS; j++) begin
      check("b2b_valid", {31'd0, m_valid}, 32'd1);
      check("b2b_data", m_data, 32'h300 + 32'h100 * 32'(j / VS) + 32'(j % VS));
      check("b2b_last", {31'd0, m_last}, (j % VS == VS - 1) ? 32'd1 : 32'd0);
      check("b2b_vec_ready", {31'd0, vec_ready},
            (j == 0 || j == VS || j >= 2 * VS) ? 32'd1 : 32'd0);
      acc = vec_valid & vec_ready;
      tick();
      if (acc) begin
        produced++;
        if (produced == 2) set_vec(32'h500);
        else begin
          vec_valid = 1'b0;
          set_vec(32'hBAD2_0000);
        end
      end else if (vec_valid) begin
        // vec_data is only sampled at acceptance; perturb the still-pending offer
        // and restore it so only its value at the accept edge matters.
        set_vec(32'hBAD3_0000);
        set_vec(produced == 1 ? 32'h400 : 32'h500);
      end
    end
    check("b2b_post_valid", {31'd0, m_valid}, 32'd0);
    check("b2b_count", {16'd0, vec_count}, 32'd3);

    // 5: reset mid-stream at idx 4 with pending full
    set_vec(32'h600);
    vec_valid = 1'b1;
    m_ready   = 1'b1;
    tick();
    set_vec(32'h700);
    tick();
    vec_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_idx", {28'd0, m_idx}, 32'd4);
    check("mid_data", m_data, 32'h604);
    check("mid_pend_full", {31'd0, vec_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_count", {16'd0, vec_count}, 32'd0);
    check("mid_rst_ready", {31'd0, vec_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("mid_idle1", {31'd0, m_valid}, 32'd0);
    tick();
    check("mid_idle2", {31'd0, m_valid}, 32'd0);
    send_and_stream("mid_new", 32'h800);
    check("mid_new_count", {16'd0, vec_count}, 32'd1);

    // 6: counter wrap on the 2-bit instance
    do_reset();
    tick();
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int v = 0; v < 5; v++) begin
      send_and_stream("wrap", 32'h900 + 32'h10 * 32'(v));
      check("wrap_count_w", {30'd0, vec_count_w}, {30'd0, wrap_exp[v]});
      check("wrap_count", {16'd0, vec_count}, 32'(v + 1));
      check("wrap_idle_w", {30'd0, m_valid_w, vec_ready_w}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
